// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg: shared state type, default sizes and index helper for the
// time-multiplexed FIR tap scheduler (fir_tap_scheduler / fir_coef_bank).
package fir_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    localparam int FIR_DEFAULT_N           = 51;
    localparam int FIR_DEFAULT_DATA_WIDTH  = 16;
    localparam int FIR_DEFAULT_COEFF_WIDTH = 16;
    localparam int FIR_DEFAULT_OUT_SHIFT   = 16;
    localparam int FIR_ACC_GUARD           = 8;
    localparam int FIR_IDX_WIDTH           = 6;

    // Guard bits keep a full-scale sum over up to 64 taps from overflowing.
    function automatic int fir_acc_width(input int dw, input int cw);
        return dw + cw + FIR_ACC_GUARD;
    endfunction

    localparam int FIR_DEFAULT_ACC_WIDTH =
        fir_acc_width(FIR_DEFAULT_DATA_WIDTH, FIR_DEFAULT_COEFF_WIDTH);

    // Circular buffer position k samples older than p: (p - k + n) mod n,
    // written without a divider since p and k are both already below n.
    function automatic logic [FIR_IDX_WIDTH-1:0] fir_circ_idx(
        input logic [FIR_IDX_WIDTH-1:0] p,
        input logic [FIR_IDX_WIDTH-1:0] k,
        input int                       n
    );
        int t;
        t = int'(p) - int'(k) + n;
        if (t >= n) begin
            t = t - n;
        end
        return FIR_IDX_WIDTH'(t);
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: double-buffered coefficient storage. The shadow bank is
// written through a simple register port at any time; the active bank only
// changes when the scheduler asserts swap_apply between samples, so a MAC
// pass always sees one consistent set of taps.
module fir_coef_bank
    import fir_sched_pkg::*;
#(
    parameter int N           = FIR_DEFAULT_N,
    parameter int COEFF_WIDTH = FIR_DEFAULT_COEFF_WIDTH
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          coef_we,
    input  logic [FIR_IDX_WIDTH-1:0]      coef_addr,
    input  logic signed [COEFF_WIDTH-1:0] coef_wdata,
    input  logic                          swap_apply,
    input  logic [FIR_IDX_WIDTH-1:0]      rd_addr,
    output logic signed [COEFF_WIDTH-1:0] rd_data
);

    logic signed [COEFF_WIDTH-1:0] shadow_bank [N];
    logic signed [COEFF_WIDTH-1:0] active_bank [N];
    logic                          addr_ok;

    assign addr_ok = (int'(coef_addr) < N);
    assign rd_data = active_bank[rd_addr];

    // Shadow bank: accepts writes in any scheduler state, out-of-range indices dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                shadow_bank[i] <= '0;
            end
        end else if (coef_we && addr_ok) begin
            shadow_bank[coef_addr] <= coef_wdata;
        end
    end

    // Active bank: whole-bank copy from shadow, only when the scheduler is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                active_bank[i] <= '0;
            end
        end else if (swap_apply) begin
            for (int i = 0; i < N; i++) begin
                active_bank[i] <= shadow_bank[i];
            end
        end
    end

endmodule

// File: rtl/fir_tap_scheduler.sv
// fir_tap_scheduler: N-tap FIR built around a single shared multiply-
// accumulate. Each accepted sample goes into a circular history buffer, then
// one tap is accumulated per clock (N clocks), and the scaled sum is held on a
// valid/ready output until taken. Coefficient swaps are deferred to an idle
// cycle and take priority over a waiting input sample.
// Build option: define FIR_ROUND_EN for round-half-up output scaling; the
// default build truncates (arithmetic shift, i.e. floor). Latency is the same.
module fir_tap_scheduler
    import fir_sched_pkg::*;
#(
    parameter int N           = FIR_DEFAULT_N,
    parameter int DATA_WIDTH  = FIR_DEFAULT_DATA_WIDTH,
    parameter int COEFF_WIDTH = FIR_DEFAULT_COEFF_WIDTH,
    parameter int ACC_WIDTH   = fir_acc_width(DATA_WIDTH, COEFF_WIDTH),
    parameter int OUT_SHIFT   = FIR_DEFAULT_OUT_SHIFT
)(
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    input  logic signed [DATA_WIDTH-1:0]              s_data,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic signed [DATA_WIDTH+COEFF_WIDTH+6:0]  m_data,
    input  logic                                      coef_we,
    input  logic [FIR_IDX_WIDTH-1:0]                  coef_addr,
    input  logic signed [COEFF_WIDTH-1:0]             coef_wdata,
    input  logic                                      coef_swap,
    output logic                                      swap_pending,
    output logic                                      busy
);

    localparam int OUT_WIDTH  = DATA_WIDTH + COEFF_WIDTH + 7;
    localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
    localparam logic [FIR_IDX_WIDTH-1:0] LAST_TAP = FIR_IDX_WIDTH'(N - 1);

    fir_state_t                    state;
    logic [FIR_IDX_WIDTH-1:0]      wr_ptr;
    logic [FIR_IDX_WIDTH-1:0]      tap;
    logic [FIR_IDX_WIDTH-1:0]      rd_idx;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic signed [COEFF_WIDTH-1:0] coef_rd;
    logic signed [DATA_WIDTH-1:0]  sample_rd;
    logic signed [PROD_WIDTH-1:0]  prod;
    logic signed [OUT_WIDTH-1:0]   scaled;
    logic signed [DATA_WIDTH-1:0]  sample_buf [N];
    logic                          swap_apply;
    logic                          accept;

    // A pending swap is only ever applied from IDLE, and blocks new samples
    // for that cycle so the copy cannot overlap a MAC pass.
    assign swap_apply = (state == IDLE) && swap_pending;
    assign s_ready    = (state == IDLE) && !swap_pending;
    assign busy       = (state != IDLE);
    assign accept     = s_valid && s_ready;

    fir_coef_bank #(
        .N           (N),
        .COEFF_WIDTH (COEFF_WIDTH)
    ) u_coef_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .swap_apply (swap_apply),
        .rd_addr    (tap),
        .rd_data    (coef_rd)
    );

    // Tap k pairs coefficient k with the sample k positions older than the newest.
    assign rd_idx    = fir_circ_idx(wr_ptr, tap, N);
    assign sample_rd = sample_buf[rd_idx];
    assign prod      = PROD_WIDTH'(coef_rd) * PROD_WIDTH'(sample_rd);
    assign acc_next  = acc + ACC_WIDTH'(prod);

`ifdef FIR_ROUND_EN
    logic signed [ACC_WIDTH:0] acc_rounded;
    assign acc_rounded = (ACC_WIDTH+1)'(acc_next)
                       + ((ACC_WIDTH+1)'(1) <<< (OUT_SHIFT - 1));
    assign scaled = OUT_WIDTH'(acc_rounded >>> OUT_SHIFT);
`else
    assign scaled = OUT_WIDTH'(acc_next >>> OUT_SHIFT);
`endif

    // Sample history: newest sample lands at wr_ptr on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                sample_buf[i] <= '0;
            end
        end else if (accept) begin
            sample_buf[wr_ptr] <= s_data;
        end
    end

    // Scheduler FSM: IDLE accepts/swaps, MAC walks all taps, OUT holds the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            tap          <= '0;
            acc          <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            swap_pending <= 1'b0;
        end else begin
            if (coef_swap) begin
                swap_pending <= 1'b1;
            end else if (swap_apply) begin
                swap_pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= '0;
                        tap   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (tap == LAST_TAP) begin
                        wr_ptr  <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;
                        m_data  <= scaled;
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// tb_fir_tap_scheduler: directed bench for fir_tap_scheduler. A behavioural
// model of the coefficient banks and sample history predicts each output when
// its sample is accepted; predictions queue up and are compared in order as
// the DUT presents results.
module tb_fir_tap_scheduler;

    localparam int N      = 51;
    localparam int DW     = 16;
    localparam int CW     = 16;
    localparam int OW     = DW + CW + 7;
    localparam int PERIOD = 10;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [OW-1:0] m_data;
    logic                 coef_we;
    logic [5:0]           coef_addr;
    logic signed [CW-1:0] coef_wdata;
    logic                 coef_swap;
    logic                 swap_pending;
    logic                 busy;

    int     checks = 0;
    int     errors = 0;
    longint expQ[$];
    longint modelShadow [N];
    longint modelActive [N];
    longint modelHist   [N];
    int     modelPtr;
    bit     modelSwapPending;
    time    lastAccept;
    time    prevAccept;
    longint got;
    int     lat;

    fir_tap_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_wdata   (coef_wdata),
        .coef_swap    (coef_swap),
        .swap_pending (swap_pending),
        .busy         (busy)
    );

    always #(PERIOD/2) clk = ~clk;

    initial begin
        #(2_000_000);
        $display("[TB] FAIL watchdog: simulation did not complete, observed=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint modelScale(input longint acc);
`ifdef FIR_ROUND_EN
        return (acc + 64'sd32768) >>> 16;
`else
        return acc >>> 16;
`endif
    endfunction

    task automatic checkVal(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            modelShadow[i] = 0;
            modelActive[i] = 0;
            modelHist[i]   = 0;
        end
        modelPtr         = 0;
        modelSwapPending = 0;
        expQ.delete();
    endtask

    task automatic coefWrite(input int addr, input int val);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = 6'(addr);
        coef_wdata = CW'(val);
        if (addr < N) modelShadow[addr] = val;
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic swapRequest();
        @(negedge clk);
        coef_swap        = 1'b1;
        modelSwapPending = 1'b1;
        @(posedge clk);
        #1 coef_swap = 1'b0;
    endtask

    task automatic applyStimulus(input int sample);
        longint acc;
        int     n;
        @(negedge clk);
        n = 0;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkVal("s_ready_wait", s_ready, 1);
        s_valid = 1'b1;
        s_data  = DW'(sample);
        if (modelSwapPending) begin
            modelActive      = modelShadow;
            modelSwapPending = 1'b0;
        end
        modelHist[modelPtr] = sample;
        acc = 0;
        for (int k = 0; k < N; k++) begin
            acc += modelActive[k] * modelHist[(modelPtr - k + N) % N];
        end
        expQ.push_back(modelScale(acc));
        modelPtr = (modelPtr + 1) % N;
        @(posedge clk);
        prevAccept = lastAccept;
        lastAccept = $time;
        #1 s_valid = 1'b0;
    endtask

    // Waits for a result, compares it with the oldest prediction, optionally
    // stalls the output for holdCycles, then completes the handshake.
    task automatic checkOutput(input string tag, input int holdCycles,
                               output longint obs, output int latency);
        longint exp;
        if (holdCycles > 0) m_ready = 1'b0;
        latency = 0;
        while (!m_valid && latency < 500) begin
            @(negedge clk);
            latency++;
        end
        checkVal({tag, "_valid"}, m_valid, 1);
        checkVal({tag, "_queued"}, (expQ.size() > 0) ? 1 : 0, 1);
        exp = (expQ.size() > 0) ? expQ.pop_front() : 0;
        obs = m_data;
        checkVal(tag, m_data, exp);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkVal({tag, "_hold_data"}, m_data, exp);
            checkVal({tag, "_hold_valid"}, m_valid, 1);
            checkVal({tag, "_hold_sready"}, s_ready, 0);
        end
        if (holdCycles > 0) begin
            @(negedge clk);
            m_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        checkVal({tag, "_drop"}, m_valid, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        m_ready    = 1'b1;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        coef_swap  = 1'b0;
        lastAccept = 0;
        prevAccept = 0;
        modelReset();

        // Reset state
        #23;
        checkVal("rst_s_ready", s_ready, 1);
        checkVal("rst_m_valid", m_valid, 0);
        checkVal("rst_m_data", m_data, 0);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_swap_pending", swap_pending, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Impulse response through h[k] = k+1
        for (int k = 0; k < N; k++) coefWrite(k, k + 1);
        coefWrite(63, 12345);
        swapRequest();
        checkVal("swap_pending_set", swap_pending, 1);
        checkVal("swap_blocks_sready", s_ready, 0);
        applyStimulus(32767);
        checkOutput("impulse0", 0, got, lat);
        checkVal("latency", lat, N + 1);
        for (int i = 1; i <= N; i++) begin
            applyStimulus(0);
            checkOutput($sformatf("impulse%0d", i), 0, got, lat);
            if (i == N - 1) checkVal("impulse_last_tap", got, 25);
            if (i == N) checkVal("impulse_tail", got, 0);
        end

        // DC response, throughput and backpressure
        for (int k = 0; k < N; k++) coefWrite(k, 1000);
        swapRequest();
        for (int i = 0; i < N + 5; i++) begin
            applyStimulus(1000);
            if (i == 1) checkVal("throughput", longint'(lastAccept - prevAccept), (N + 2) * PERIOD);
            checkOutput($sformatf("dc%0d", i), (i == N + 2) ? 20 : 0, got, lat);
            if (i == 0) checkVal("dc_ramp_first", got, 15);
        end
        checkVal("dc_steady", got, 778);

        // Swap requested mid-MAC, with a same-cycle shadow write
        for (int k = 0; k < N; k++) coefWrite(k, 0);
        coefWrite(0, 3000);
        applyStimulus(500);
        repeat (9) @(negedge clk);
        @(negedge clk);
        coef_swap        = 1'b1;
        coef_we          = 1'b1;
        coef_addr        = 6'd2;
        coef_wdata       = 16'sd7000;
        modelShadow[2]   = 7000;
        modelSwapPending = 1'b1;
        @(posedge clk);
        #1;
        coef_swap = 1'b0;
        coef_we   = 1'b0;
        checkVal("swap_mid_busy", busy, 1);
        checkVal("swap_mid_pending", swap_pending, 1);
        checkOutput("swap_old_bank", 0, got, lat);
        checkVal("swap_pending_idle", swap_pending, 1);
        checkVal("swap_idle_sready", s_ready, 0);
        applyStimulus(20000);
        checkVal("swap_pending_clear", swap_pending, 0);
        checkOutput("swap_new_bank", 0, got, lat);
        checkVal("swap_new_value", got, 1022);

        // Reset during MAC discards the result and the history
        applyStimulus(12345);
        repeat (25) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkVal("rstmac_m_valid", m_valid, 0);
        checkVal("rstmac_busy", busy, 0);
        checkVal("rstmac_s_ready", s_ready, 1);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        coefWrite(0, 20000);
        coefWrite(1, 10000);
        coefWrite(2, -10000);
        coefWrite(3, 5000);
        swapRequest();
        applyStimulus(30000);
        checkOutput("clean0", 0, got, lat);
        checkVal("clean0_value", got, 9155);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(0);
            checkOutput($sformatf("clean%0d", i), 0, got, lat);
        end

        // Reset while a result is stalled in OUT
        m_ready = 1'b0;
        applyStimulus(1000);
        lat = 0;
        while (!m_valid && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        checkVal("rstout_valid_before", m_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        checkVal("rstout_m_valid", m_valid, 0);
        checkVal("rstout_m_data", m_data, 0);
        modelReset();
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;

        // Output scaling at the half-LSB boundary, positive and negative
        coefWrite(0, 2);
        swapRequest();
        applyStimulus(16384);
        checkOutput("round_pos", 0, got, lat);
`ifdef FIR_ROUND_EN
        checkVal("round_pos_value", got, 1);
`else
        checkVal("round_pos_value", got, 0);
`endif
        coefWrite(0, 1);
        swapRequest();
        applyStimulus(-1);
        checkOutput("round_neg", 0, got, lat);
`ifdef FIR_ROUND_EN
        checkVal("round_neg_value", got, 0);
`else
        checkVal("round_neg_value", got, -1);
`endif

        checkVal("queue_empty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_tap_scheduler.md
Name: fir_tap_scheduler

Overview:
Time-multiplexed sequencer for a 51-tap FIR. It accepts one input sample per valid/ready handshake, writes the sample into a circular sample buffer, and steps one shared MAC across all N taps. It then presents the scaled result on a valid/ready output. Coefficients are double-buffered: a shadow bank is written over a simple register port, and a swap request copies it into the active bank between samples. The block sits between the ADC sample stream and downstream decimation/DSP logic and replaces the fully-parallel filter where DSP slices are scarce.

Parameters:
N, 51, number of taps (must be at least 2 and at most 64)
DATA_WIDTH, 16, input sample width, signed
COEFF_WIDTH, 16, coefficient width, signed Q15
ACC_WIDTH, DATA_WIDTH+COEFF_WIDTH+8, accumulator width
OUT_SHIFT, 16, arithmetic right shift applied to the accumulator before output

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input sample valid
s_ready  out  1  block can accept a sample
s_data  in  DATA_WIDTH  signed input sample
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_data  out  DATA_WIDTH+COEFF_WIDTH+7  signed filtered result
coef_we  in  1  shadow coefficient write strobe
coef_addr  in  6  shadow coefficient index
coef_wdata  in  COEFF_WIDTH  signed coefficient value
coef_swap  in  1  one-cycle request to copy shadow bank into active bank
swap_pending  out  1  a swap request has been accepted but not yet applied
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE; s_ready=1; m_valid=0; m_data=0; busy=0; swap_pending=0.
  - Sample buffer, both coefficient banks, accumulator, write pointer and tap counter all cleared to 0.
- States: IDLE, MAC, OUT.
- IDLE:
  - s_ready=1 only when swap_pending=0.
  - If swap_pending=1, the active bank is loaded from the shadow bank on this edge, swap_pending clears, and the state stays IDLE for that cycle.
  - Otherwise, on s_valid&&s_ready: write s_data at wr_ptr, clear acc, set tap counter k=0, go to MAC.
- MAC:
  - One tap per cycle: acc += active[k] * buf[(wr_ptr_at_accept - k) mod N].
  - The newest sample pairs with coefficient 0.
  - After k=N-1 is accumulated, advance wr_ptr (wrapping N-1 to 0) and go to OUT.
  - Takes exactly N cycles.
- OUT:
  - m_valid=1; m_data = acc >>> OUT_SHIFT, truncated to the m_data width.
  - m_data stays stable while m_valid=1 and m_ready=0.
  - On m_ready, go to IDLE.
- Latency and throughput:
  - Accept edge E0; m_valid rises after edge E0+N (visible in cycle N+1).
  - With m_ready held high, one result every N+2 cycles.
- Coefficient port:
  - coef_we writes the shadow bank in any state.
  - coef_addr >= N is ignored.
  - Shadow writes never affect a MAC in progress.
- coef_swap:
  - Sets swap_pending in any state.
  - A coef_we and a coef_swap in the same cycle: the write lands in the shadow bank before the copy.
  - A swap is never applied mid-sample. The active bank is constant across all N taps of one output.
- Simultaneous s_valid and swap_pending in IDLE: the swap wins and the sample waits (s_ready=0).
- Reset asserted mid-MAC or mid-OUT: the result is discarded, m_valid drops immediately, and the sample history is lost.
- Arithmetic is fully signed. The accumulator does not overflow for N<=64 at full-scale inputs.

Optional Feature:
Macro FIR_ROUND_EN.
- Defined: m_data = (acc + (1 <<< (OUT_SHIFT-1))) >>> OUT_SHIFT, i.e. round-half-up.
- Undefined: plain truncating arithmetic shift (floor).
- Latency is identical in both builds.

Decomposition:
- Package fir_sched_pkg holds:
  - the state enum (IDLE/MAC/OUT);
  - default N and widths;
  - ACC_WIDTH derivation;
  - the circular-index helper function ((p - k + N) mod N).
- One natural sub-module: fir_coef_bank. It holds the shadow and active register banks, the write port, the swap copy, and a read port addressed by k.

Test Plan:
- Impulse: active bank h[k]=k+1 (via shadow write plus swap), then input 32767 followed by 0s. The first N outputs must equal floor(32767*(k+1)/65536) for k=0..N-1, then 0.
- DC: all h[k]=1000, input constant 1000 for N+5 samples. Steady output must be floor(51*1000*1000/65536)=778, and outputs ramp before steady state.
- Backpressure: hold m_ready=0 for 20 cycles after m_valid. m_data stays stable, s_ready=0, and no result is lost or duplicated.
- Swap during MAC: pulse coef_swap at tap 10. The current output uses the old bank, swap_pending=1 until the next IDLE cycle, and the next sample uses the new bank.
- Reset mid-MAC: drop rst_n at tap 25. m_valid=0 immediately. After release, an impulse produces a clean response with no stale history.
- Rounding: acc=0x8000 with OUT_SHIFT=16 gives m_data=1 under FIR_ROUND_EN and 0 without it. Negative acc=-1 gives 0 and -1 respectively.
